card_dealer: RTL and testbench
==============================

# card_dealer

Deck shuffler and dealer for the card game datapath. Holds a 52-card deck as 6-bit card indices (0–51), shuffles it with an LFSR-driven Fisher–Yates pass, then hands out one card per request. Its `card_bit` output feeds the suit/rank decoder directly, where suit = index / 13 and rank = index % 13.

## Interface
Parameters:
- `DECK_SIZE`, 52, number of cards; the index range is 0..DECK_SIZE-1.
- `CARD_W`, 6, card index width.
- `DEFAULT_SEED`, 16'hACE1, substituted when `seed` is 0.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `shuffle_req`  in  1  start a new shuffle; sampled on the clock edge.
- `seed`  in  16  LFSR seed, captured when `shuffle_req` is accepted.
- `deal_req`  in  1  request the next card.
- `card_valid`  out  1  one-cycle pulse; `card_bit` is valid.
- `card_bit`  out  6  dealt card index, 0–51.
- `cards_left`  out  6  undealt cards remaining in the deck.
- `deck_empty`  out  1  high when `cards_left` is 0.
- `busy`  out  1  high while shuffling.

## Operation
- States:
  - IDLE: after reset; no deck loaded.
  - SHUFFLE
  - READY
- The deck is a register array `deck[0:51]` of 6-bit entries. Swaps complete in one cycle.
- **Shuffle start.** In IDLE or READY, a sampled `shuffle_req` does the following on the same edge:
  - `deck[k] <= k` for all k.
  - `lfsr <= (seed==0) ? DEFAULT_SEED : seed`.
  - `i <= 51`, `cards_left <= 0`, `busy <= 1`.
  - State goes to SHUFFLE.
- **LFSR.** 16-bit Galois, right shift, taps mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - It advances once per SHUFFLE cycle, unconditionally.
  - It never holds 0.
- **SHUFFLE cycle.**
  - `r = lfsr[5:0]` (current value).
  - If `r <= i`: swap `deck[i]` and `deck[r]`, then `i <= i-1`. When r == i the swap is a no-op but still counts as accepted.
  - Otherwise the cycle is rejected: no swap, `i` holds.
  - This rejection sampling gives an unbiased index without a divider.
- **Shuffle end.** On the edge that accepts at `i==1`:
  - State goes to READY.
  - `cards_left <= 52`, `ptr <= 0`, `busy <= 0`.
- **Deal.** In READY with `deal_req==1` and `cards_left != 0`, on that edge:
  - `card_bit <= deck[ptr]`, `card_valid <= 1`.
  - `ptr <= ptr+1`, `cards_left <= cards_left-1`.
- **Deal ignored.** `deal_req` produces no pulse in each of these cases:
  - In IDLE or SHUFFLE.
  - In READY with `cards_left==0`.
- **Simultaneous requests.** With `shuffle_req` and `deal_req` both high in READY, the shuffle wins and no card is dealt.
- `shuffle_req` during SHUFFLE is ignored. The shuffle in progress continues.
- `deck_empty` is registered and equals `cards_left==0`. It is therefore high in IDLE and SHUFFLE.
- **Reset values:**
  - `card_valid=0`, `card_bit=0`, `cards_left=0`, `deck_empty=1`, `busy=0`.
  - State IDLE, `ptr=0`, `i=0`.
  - LFSR = `DEFAULT_SEED`.
  - Deck contents are don't-care.
- Reset asserted mid-shuffle or mid-deal forces the reset values on that edge. The partial deck is discarded.

## Timing
- `shuffle_req` sampled at edge N: `busy=1` and `cards_left=0` are visible after edge N.
- Shuffle duration is data-dependent.
  - Minimum 51 cycles.
  - Expected about 225 cycles.
  - Always finite, because the LFSR is maximal-length and every 6-bit low pattern recurs.
- `busy` falls on the same edge on which `cards_left` becomes 52.
- Deal latency is 1 cycle: `deal_req` at edge N gives `card_valid`/`card_bit` after edge N.
- Back-to-back deals are allowed, one card per cycle.
- `card_bit` holds its last value when `card_valid=0`.
- The 52nd deal drives `cards_left` to 0 and `deck_empty` to 1 on the same edge.

## Structure
- **Package `card_pkg`:**
  - `DECK_SIZE`, `CARD_W`, `LFSR_TAPS = 16'hB400`, `DEFAULT_SEED`.
  - State enum `dealer_state_t {IDLE, SHUFFLE, READY}`.
  - Shared with the suit/rank decoder.
- **Sub-module `card_lfsr`:**
  - Ports: `clk`, `rst_n`, `load`, `load_val[15:0]`, `step`, `value[15:0]`.
  - Reset and zero-seed substitution are handled inside `card_lfsr`.
- **Top level:** the FSM, the deck array, and the `ptr`/`i`/`cards_left` counters.

## Test plan
- **Reset values.** Hold `rst_n=0` for 3 cycles, release with no requests. Required: `card_valid=0`, `card_bit=0`, `cards_left=0`, `deck_empty=1`, `busy=0`. `deal_req` pulses give no `card_valid`.
- **Full deal.** Seed 16'h1234 with `shuffle_req`, wait for `busy` to fall, then deal 52 cards back-to-back. Required:
  - 52 consecutive `card_valid` pulses.
  - The values form a permutation of 0..51.
  - `cards_left` counts 52→0, and `deck_empty` rises with the last card.
  - The sequence matches a reference model of the LFSR and Fisher–Yates pass bit-exactly.
- **Repeatability and zero seed.** Two shuffles with seed 0 give identical sequences, equal to a shuffle with seed 16'hACE1. A shuffle with seed 16'h0001 gives a different sequence.
- **Empty deck and ignored requests.** A 53rd `deal_req` after empty gives no pulse and `cards_left` stays 0. `deal_req` and `shuffle_req` held high during SHUFFLE change nothing; the final deck equals the clean-run deck.
- **Request priority.** In READY with 10 cards dealt, assert `shuffle_req` and `deal_req` together. Required: no `card_valid`, `busy=1`, `cards_left=0` next cycle.
- **Reset mid-shuffle.** Pull `rst_n` low 20 cycles into a shuffle. Required: reset values next cycle and state IDLE. A fresh shuffle with the same seed then reproduces the clean-run sequence.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card constants, dealer state encoding and the LFSR step function.
// Also used by the downstream suit/rank decoder (suit = idx / 13, rank = idx % 13).
package card_pkg;

  localparam int          DECK_SIZE    = 52;
  localparam int          CARD_W       = 6;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    READY   = 2'd2
  } dealer_state_t;

  // Galois right-shift step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ ({16{v[0]}} & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit maximal-length Galois LFSR with seed load; a zero seed is replaced by
// SEED_DEFAULT so the register can never lock up at 0. Load has priority over step.
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = card_pkg::DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED_DEFAULT;
    end else if (load) begin
      lfsr_q <= (load_val == 16'd0) ? SEED_DEFAULT : load_val;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Deck shuffler/dealer: rejection-sampled Fisher-Yates shuffle driven by card_lfsr,
// then one card per deal_req with 1-cycle latency; shuffle_req outranks deal_req.
module card_dealer
  import card_pkg::*;
#(
  parameter int          DECK_SIZE    = card_pkg::DECK_SIZE,
  parameter int          CARD_W       = card_pkg::CARD_W,
  parameter logic [15:0] DEFAULT_SEED = card_pkg::DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shuffle_req,
  input  logic [15:0]       seed,
  input  logic              deal_req,
  output logic              card_valid,
  output logic [CARD_W-1:0] card_bit,
  output logic [CARD_W-1:0] cards_left,
  output logic              deck_empty,
  output logic              busy
);

  localparam logic [CARD_W-1:0] LAST_IDX  = CARD_W'(DECK_SIZE - 1);
  localparam logic [CARD_W-1:0] FULL_DECK = CARD_W'(DECK_SIZE);
  localparam logic [CARD_W-1:0] ONE       = CARD_W'(1);

  dealer_state_t     state_q;
  logic [CARD_W-1:0] deck_q [0:DECK_SIZE-1];
  logic [CARD_W-1:0] i_q;
  logic [CARD_W-1:0] ptr_q;
  logic [CARD_W-1:0] cards_left_q;
  logic              deck_empty_q;
  logic              busy_q;
  logic              card_valid_q;
  logic [CARD_W-1:0] card_bit_q;

  logic [15:0]       lfsr_val;
  logic [CARD_W-1:0] rnd;
  logic              swap_ok;
  logic              shuffle_start;
  logic              lfsr_unused;

  assign shuffle_start = shuffle_req && (state_q != SHUFFLE);
  assign rnd           = lfsr_val[CARD_W-1:0];
  assign swap_ok       = (rnd <= i_q);
  assign lfsr_unused   = ^lfsr_val[15:CARD_W];

  card_lfsr #(
    .SEED_DEFAULT(DEFAULT_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (shuffle_start),
    .load_val(seed),
    .step    (state_q == SHUFFLE),
    .value   (lfsr_val)
  );

  // Deck contents are intentionally left out of reset; they are rebuilt on every shuffle start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      ptr_q        <= '0;
      cards_left_q <= '0;
      deck_empty_q <= 1'b1;
      busy_q       <= 1'b0;
      card_valid_q <= 1'b0;
      card_bit_q   <= '0;
    end else begin
      card_valid_q <= 1'b0;
      case (state_q)
        IDLE, READY: begin
          if (shuffle_req) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
              deck_q[k] <= CARD_W'(k);
            end
            i_q          <= LAST_IDX;
            cards_left_q <= '0;
            deck_empty_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= SHUFFLE;
          end else if ((state_q == READY) && deal_req && (cards_left_q != '0)) begin
            card_bit_q   <= deck_q[ptr_q];
            card_valid_q <= 1'b1;
            ptr_q        <= ptr_q + ONE;
            cards_left_q <= cards_left_q - ONE;
            deck_empty_q <= (cards_left_q == ONE);
          end
        end
        SHUFFLE: begin
          // Out-of-range draws are simply retried on the next LFSR value.
          if (swap_ok) begin
            deck_q[i_q] <= deck_q[rnd];
            deck_q[rnd] <= deck_q[i_q];
            i_q         <= i_q - ONE;
            if (i_q == ONE) begin
              state_q      <= READY;
              cards_left_q <= FULL_DECK;
              deck_empty_q <= 1'b0;
              ptr_q        <= '0;
              busy_q       <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign card_valid = card_valid_q;
  assign card_bit   = card_bit_q;
  assign cards_left = cards_left_q;
  assign deck_empty = deck_empty_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed/random bench for card_dealer against a plain-arithmetic shuffle model.
module tb_card_dealer;
  import card_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        shuffle_req;
  logic [15:0] seed;
  logic        deal_req;
  logic        card_valid;
  logic [5:0]  card_bit;
  logic [5:0]  cards_left;
  logic        deck_empty;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_deck [52];
  int exp_cycles;
  int got [52];
  int ace_deck [52];

  card_dealer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .shuffle_req(shuffle_req),
    .seed       (seed),
    .deal_req   (deal_req),
    .card_valid (card_valid),
    .card_bit   (card_bit),
    .cards_left (cards_left),
    .deck_empty (deck_empty),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: textbook Fisher-Yates with draws rejected when lfsr mod 64 exceeds i.
  task automatic model(input logic [15:0] s);
    logic [15:0] l;
    int d [52];
    int i, r, t;
    l = s;
    for (int k = 0; k < 52; k++) d[k] = k;
    i = 51;
    exp_cycles = 0;
    while (i >= 1 && exp_cycles < 100000) begin
      r = int'(l) % 64;
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      exp_cycles++;
      if (r <= i) begin
        t = d[i]; d[i] = d[r]; d[r] = t;
        i--;
      end
    end
    for (int k = 0; k < 52; k++) exp_deck[k] = d[k];
  endtask

  task automatic wait_done(input logic [15:0] sd, input bit noise);
    bit done = 0;
    for (int n = 1; n <= 4000 && !done; n++) begin
      if (noise && n <= 30) begin
        deal_req = 1'b1; shuffle_req = 1'b1; seed = 16'h5555;
      end else begin
        deal_req = 1'b0; shuffle_req = 1'b0; seed = sd;
      end
      tick();
      if (noise && n <= 30) chk("noise_no_valid", 32'(card_valid), 32'd0);
      if (!busy) begin
        done = 1;
        chk("shuffle_cycles", 32'(n), 32'(exp_cycles));
      end
    end
    deal_req = 1'b0; shuffle_req = 1'b0;
    chk("shuffle_done", 32'(done), 32'd1);
    chk("full_cards_left", 32'(cards_left), 32'd52);
    chk("full_not_empty", 32'(deck_empty), 32'd0);
  endtask

  task automatic run_shuffle(input logic [15:0] sd, input logic [15:0] model_sd, input bit noise);
    model(model_sd);
    seed = sd; shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cards_left", 32'(cards_left), 32'd0);
    chk("start_empty", 32'(deck_empty), 32'd1);
    wait_done(sd, noise);
  endtask

  task automatic deal_cards(input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) begin
      deal_req = 1'b1;
      tick();
      got[k] = int'(card_bit);
      chk("deal_valid", 32'(card_valid), 32'd1);
      chk("deal_card", 32'(card_bit), 32'(exp_deck[k]));
      chk("deal_left", 32'(cards_left), 32'(51 - k));
      chk("deal_empty", 32'(deck_empty), 32'(k == 51));
    end
    deal_req = 1'b0;
  endtask

  initial begin
    int distinct, ndiff;
    bit seen [52];
    rst_n = 1'b0; shuffle_req = 1'b0; deal_req = 1'b0; seed = 16'h0;

    // Reset values and deal requests in IDLE.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 32'(card_valid), 32'd0);
    chk("rst_card", 32'(card_bit), 32'd0);
    chk("rst_left", 32'(cards_left), 32'd0);
    chk("rst_empty", 32'(deck_empty), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      deal_req = 1'b1;
      tick();
      chk("idle_deal_valid", 32'(card_valid), 32'd0);
    end
    deal_req = 1'b0;

    // Full deal, permutation, and one deal past empty.
    run_shuffle(16'h1234, 16'h1234, 0);
    deal_cards(0, 52);
    for (int k = 0; k < 52; k++) seen[k] = 0;
    distinct = 0;
    for (int k = 0; k < 52; k++)
      if (got[k] < 52 && !seen[got[k]]) begin seen[got[k]] = 1; distinct++; end
    chk("permutation", 32'(distinct), 32'd52);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("extra_deal_valid", 32'(card_valid), 32'd0);
    chk("extra_deal_left", 32'(cards_left), 32'd0);
    chk("extra_deal_empty", 32'(deck_empty), 32'd1);
    chk("card_bit_hold", 32'(card_bit), 32'(exp_deck[51]));

    // Zero seed maps to the default seed, repeatably.
    run_shuffle(16'h0000, 16'hACE1, 0);
    deal_cards(0, 52);
    run_shuffle(16'h0000, 16'hACE1, 0);
    deal_cards(0, 52);
    run_shuffle(16'hACE1, 16'hACE1, 0);
    deal_cards(0, 52);
    for (int k = 0; k < 52; k++) ace_deck[k] = exp_deck[k];

    run_shuffle(16'h0001, 16'h0001, 0);
    deal_cards(0, 52);
    ndiff = 0;
    for (int k = 0; k < 52; k++) if (got[k] != ace_deck[k]) ndiff++;
    chk("seed1_differs", 32'(ndiff != 0), 32'd1);

    // Requests during SHUFFLE are ignored.
    run_shuffle(16'h1234, 16'h1234, 1);
    deal_cards(0, 52);

    // Random seeds.
    for (int t = 0; t < 3; t++) begin
      logic [15:0] rs;
      rs = 16'($urandom_range(1, 65535));
      run_shuffle(rs, rs, 0);
      deal_cards(0, 52);
    end

    // Shuffle outranks deal in READY.
    run_shuffle(16'h1234, 16'h1234, 0);
    deal_cards(0, 10);
    seed = 16'h1234; shuffle_req = 1'b1; deal_req = 1'b1;
    tick();
    shuffle_req = 1'b0; deal_req = 1'b0;
    chk("prio_no_valid", 32'(card_valid), 32'd0);
    chk("prio_busy", 32'(busy), 32'd1);
    chk("prio_left", 32'(cards_left), 32'd0);
    chk("prio_card_hold", 32'(card_bit), 32'(exp_deck[9]));
    wait_done(16'h1234, 0);
    deal_cards(0, 52);

    // Reset in the middle of a shuffle.
    seed = 16'h1234; shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(card_valid), 32'd0);
    chk("midrst_card", 32'(card_bit), 32'd0);
    chk("midrst_left", 32'(cards_left), 32'd0);
    chk("midrst_empty", 32'(deck_empty), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    run_shuffle(16'h1234, 16'h1234, 0);
    deal_cards(0, 52);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
